// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite copy engine: one NONSEQ word read, then its write.
// Optional fill mode (no reads, constant data) under AHB_DMA_FILL_EN.
module ahb_dma_master #(
  parameter int LENW = 16
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            start,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  input  logic [LENW-1:0] len_words,
`ifdef AHB_DMA_FILL_EN
  input  logic            fill_mode,
  input  logic [31:0]     fill_value,
`endif
  output logic            busy,
  output logic            done,
  output logic [31:0]     HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [31:0]     HWDATA,
  input  logic [31:0]     HRDATA,
  input  logic            HREADY
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_A, WR_D, DONE
  } state_t;

  state_t          state;
  logic [31:0]     src_p;
  logic [31:0]     dst_p;
  logic [LENW-1:0] cnt;
  logic [31:0]     buf_q;
  logic            fill_q;
  logic            fill_w;
  logic [31:0]     fill_v;
  logic [31:0]     src_al;
  logic [31:0]     dst_al;

`ifdef AHB_DMA_FILL_EN
  assign fill_w = fill_mode;
  assign fill_v = fill_value;
`else
  assign fill_w = 1'b0;
  assign fill_v = 32'h0;
`endif

  assign src_al = src_addr & ~32'd3;
  assign dst_al = dst_addr & ~32'd3;
  assign HSIZE  = 3'b010;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      src_p  <= '0;
      dst_p  <= '0;
      cnt    <= '0;
      buf_q  <= '0;
      fill_q <= 1'b0;
      HADDR  <= '0;
      HTRANS <= T_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          busy   <= 1'b1;
          src_p  <= src_al;
          dst_p  <= dst_al;
          cnt    <= len_words;
          fill_q <= fill_w;
          if (fill_w) buf_q <= fill_v;
          if (len_words == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (fill_w) begin
            state  <= WR_A;
            HTRANS <= T_NONSEQ;
            HWRITE <= 1'b1;
            HADDR  <= dst_al;
          end else begin
            state  <= RD_A;
            HTRANS <= T_NONSEQ;
            HWRITE <= 1'b0;
            HADDR  <= src_al;
          end
        end
        RD_A: if (HREADY) begin
          state  <= RD_D;
          HTRANS <= T_IDLE;
        end
        RD_D: if (HREADY) begin
          buf_q  <= HRDATA;
          state  <= WR_A;
          HTRANS <= T_NONSEQ;
          HWRITE <= 1'b1;
          HADDR  <= dst_p;
        end
        WR_A: if (HREADY) begin
          state  <= WR_D;
          HTRANS <= T_IDLE;
          HWDATA <= buf_q;
        end
        WR_D: if (HREADY) begin
          src_p <= src_p + 32'd4;
          dst_p <= dst_p + 32'd4;
          cnt   <= cnt - LENW'(1);
          if (cnt == LENW'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            HWRITE <= 1'b0;
          end else if (fill_q) begin
            state  <= WR_A;
            HTRANS <= T_NONSEQ;
            HADDR  <= dst_p + 32'd4;
          end else begin
            state  <= RD_A;
            HTRANS <= T_NONSEQ;
            HWRITE <= 1'b0;
            HADDR  <= src_p + 32'd4;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Bench for ahb_dma_master: memory slave with optional waits,
// transfer scoreboard, cycle-exact busy/done checks.
module tb_ahb_dma_master;

  localparam int LENW = 16;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     src_addr = '0;
  logic [31:0]     dst_addr = '0;
  logic [LENW-1:0] len_words = '0;
`ifdef AHB_DMA_FILL_EN
  logic            fill_mode = 1'b0;
  logic [31:0]     fill_value = '0;
`endif
  logic            busy;
  logic            done;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [31:0]     HWDATA;
  logic [31:0]     HRDATA = '0;
  logic            HREADY;

  ahb_dma_master #(.LENW(LENW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
`ifdef AHB_DMA_FILL_EN
    .fill_mode (fill_mode),
    .fill_value(fill_value),
`endif
    .busy      (busy),
    .done      (done),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       exq[$];
  xfer_t       pexp;
  int          checks = 0;
  int          errors = 0;
  int          nxfer = 0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic void push(input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
    xfer_t x;
    x.wr = wr;
    x.a  = a;
    x.d  = d;
    exq.push_back(x);
  endfunction

  // slave wait-state generator: two HREADY=0 cycles at the start of each phase
  logic       wait_en = 1'b0;
  logic [1:0] wcnt = '0;
  assign HREADY = !wait_en || wcnt == 2'd2;
  always @(posedge HCLK)
    if (!busy || HREADY) wcnt <= '0;
    else wcnt <= wcnt + 2'd1;

  logic        pend = 1'b0;
  logic        pwr = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] ph_addr = '0;
  logic [31:0] ph_wdata = '0;
  logic [1:0]  ph_trans = '0;
  logic        ph_write = 1'b0;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      pend = 1'b0;
    end else begin
      if (wait_en && !HREADY && wcnt != 2'd0) begin
        chk("hold_haddr", HADDR, ph_addr);
        chk("hold_htrans", 32'(HTRANS), 32'(ph_trans));
        chk("hold_hwrite", 32'(HWRITE), 32'(ph_write));
        chk("hold_hwdata", HWDATA, ph_wdata);
      end
      if (pend && HREADY) begin
        if (pwr) begin
          chk("hwdata", HWDATA, pexp.d);
          mem[paddr] = HWDATA;
        end
        pend = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        nxfer++;
        chk("xfer_expected", 32'(exq.size() != 0), 32'd1);
        if (exq.size() != 0) begin
          pexp = exq.pop_front();
          chk("haddr", HADDR, pexp.a);
          chk("hwrite", 32'(HWRITE), 32'(pexp.wr));
          chk("hsize", 32'(HSIZE), 32'd2);
        end
        pend  = 1'b1;
        pwr   = HWRITE;
        paddr = HADDR;
        if (!HWRITE) HRDATA = rdm(HADDR);
      end
    end
    ph_addr  = HADDR;
    ph_wdata = HWDATA;
    ph_trans = HTRANS;
    ph_write = HWRITE;
  end

  task automatic run(input logic [31:0] s, input logic [31:0] d,
                     input int n, input logic fm,
                     input logic [31:0] fv, input int exp_done,
                     input int poke);
    int k0;
    logic [31:0] sa, da;
    k0 = nxfer;
    sa = s & ~32'd3;
    da = d & ~32'd3;
    for (int i = 0; i < n; i++) begin
      if (!fm) begin
        push(1'b0, 32'(sa + 32'(4 * i)), 32'h0);
        push(1'b1, 32'(da + 32'(4 * i)), rdm(32'(sa + 32'(4 * i))));
      end else begin
        push(1'b1, 32'(da + 32'(4 * i)), fv);
      end
    end
    @(negedge HCLK);
    start     = 1'b1;
    src_addr  = s;
    dst_addr  = d;
    len_words = LENW'(n);
`ifdef AHB_DMA_FILL_EN
    fill_mode  = fm;
    fill_value = fv;
`endif
    @(posedge HCLK);
    #1;
    start     = 1'b0;
    src_addr  = ~s;
    dst_addr  = ~d;
    len_words = LENW'(7);
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge HCLK);
      chk($sformatf("busy@%0d", k), 32'(busy), 32'(k <= exp_done));
      chk($sformatf("done@%0d", k), 32'(done), 32'(k == exp_done));
      start = (k == poke);
    end
    start = 1'b0;
    chk("xfer_count", 32'(nxfer - k0), 32'(fm ? n : 2 * n));
    chk("queue_empty", 32'(exq.size()), 32'd0);
  endtask

  initial begin
    mem[32'h100] = 32'h11111111;
    mem[32'h104] = 32'h22222222;
    mem[32'h108] = 32'h33333333;
    mem[32'h10C] = 32'h44444444;

    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // zero-wait copy of three words
    run(32'h100, 32'h200, 3, 1'b0, 32'h0, 13, 0);
    chk("mem200", rdm(32'h200), 32'h11111111);
    chk("mem204", rdm(32'h204), 32'h22222222);
    chk("mem208", rdm(32'h208), 32'h33333333);

    // two wait states per phase
    wait_en = 1'b1;
    run(32'h104, 32'h280, 1, 1'b0, 32'h0, 13, 0);
    wait_en = 1'b0;
    chk("mem280", rdm(32'h280), 32'h22222222);

    // zero length
    run(32'h100, 32'h900, 0, 1'b0, 32'h0, 1, 0);

    // unaligned addresses, destination wraps through zero
    run(32'h103, 32'hFFFFFFFE, 2, 1'b0, 32'h0, 9, 0);
    chk("memFFC", rdm(32'hFFFFFFFC), 32'h11111111);
    chk("mem000", rdm(32'h0), 32'h22222222);

    // start pulsed while busy is ignored
    run(32'h100, 32'h400, 4, 1'b0, 32'h0, 17, 6);
    chk("mem40C", rdm(32'h40C), 32'h44444444);

    // reset during WR_A of the second word
    begin
      for (int i = 0; i < 4; i++) begin
        push(1'b0, 32'(32'h100 + 32'(4 * i)), 32'h0);
        push(1'b1, 32'(32'h600 + 32'(4 * i)), rdm(32'(32'h100 + 32'(4 * i))));
      end
      @(negedge HCLK);
      start     = 1'b1;
      src_addr  = 32'h100;
      dst_addr  = 32'h600;
      len_words = LENW'(4);
      @(posedge HCLK);
      #1 start = 1'b0;
      repeat (7) @(negedge HCLK);
      chk("pre_rst_htrans", 32'(HTRANS), 32'd2);
      chk("pre_rst_hwrite", 32'(HWRITE), 32'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("mid_rst_htrans", 32'(HTRANS), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_haddr", HADDR, 32'h0);
      exq.delete();
      @(negedge HCLK);
      #2 HRESETn = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge HCLK);
        chk("post_rst_htrans", 32'(HTRANS), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
      end
      chk("mem600", rdm(32'h600), 32'h11111111);
      chk("mem604", rdm(32'h604), 32'h0);
    end

    // block still works after the abandoned copy
    run(32'h108, 32'h700, 1, 1'b0, 32'h0, 5, 0);
    chk("mem700", rdm(32'h700), 32'h33333333);

`ifdef AHB_DMA_FILL_EN
    run(32'h100, 32'h300, 4, 1'b1, 32'hDEADBEEF, 9, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fill%0d", i), rdm(32'(32'h300 + 32'(4 * i))), 32'hDEADBEEF);
    fill_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_dma_master.md
Name: ahb_dma_master

Overview:
- Single-channel AHB-Lite initiator.
- Copies a block of 32-bit words from a source address to a destination address in the SoC address space, e.g. between AHB BRAM regions or into peripheral registers.
- Sits on the master side of the AHB-Lite interconnect, alongside the CPU master through an arbiter.
- Issues single-beat, non-pipelined NONSEQ word transfers: each read is followed by its matching write.

Parameters:
- LENW, 16, width of the transfer-length (word count) input and internal counter.

Ports:
- HCLK  input  1  system clock; all logic on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  input  32  destination byte address; bits [1:0] ignored.
- len_words  input  LENW  number of words to copy.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
- done  output  1  one-cycle completion pulse.
- HADDR  output  32  AHB address.
- HTRANS  output  2  2'b10 (NONSEQ) or 2'b00 (IDLE) only.
- HWRITE  output  1  AHB write enable.
- HSIZE  output  3  constant 3'b010 (word).
- HWDATA  output  32  write data, valid during write data phase.
- HRDATA  input  32  read data from the slave mux.
- HREADY  input  1  transfer-completion / wait-state signal from the slave mux.

Behaviour:
- Reset (async, immediate) values: HADDR=0, HTRANS=2'b00, HWRITE=0, HWDATA=0, busy=0, done=0, state=IDLE. All outputs registered.
- States are IDLE, RD_A, RD_D, WR_A, WR_D, DONE.
- IDLE:
  - On start=1 with len_words!=0: latch src/dst (word-aligned) and count=len_words; go to RD_A.
  - On start=1 with len_words==0: go to DONE; no bus activity.
- RD_A: HTRANS=NONSEQ, HWRITE=0, HADDR=src pointer. Hold all of these stable until an edge with HREADY=1, then go to RD_D.
- RD_D: HTRANS=IDLE. At an edge with HREADY=1, capture HRDATA into the data buffer and go to WR_A. While HREADY=0, stay.
- WR_A: HTRANS=NONSEQ, HWRITE=1, HADDR=dst pointer. Hold until HREADY=1, then go to WR_D.
- WR_D:
  - HTRANS=IDLE, HWDATA=buffer, held stable while HREADY=0.
  - On HREADY=1: src+=4, dst+=4, count-=1. If count becomes 0, go to DONE; else go to RD_A.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy is 1 in DONE.
- Latency with zero wait states: 4 cycles per word. done is high in cycle 4*len_words+1 after the accepting edge; for len_words=0 it is high in cycle 1.
- Each wait state (HREADY=0) adds one cycle in the phase where it occurs.
- Pointers wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000). There is no boundary check.
- start while busy is ignored; no queuing.
- Inputs src_addr, dst_addr and len_words may change after acceptance without effect.
- Reset mid-transfer: the bus returns to IDLE immediately and the partial copy is abandoned. No done pulse.
- No HRESP handling; all interconnect slaves are OKAY-only.

Optional Feature:
- Macro AHB_DMA_FILL_EN.
- When defined, two extra input ports are added:
  - fill_mode (1 bit), latched with start.
  - fill_value (32 bits), latched with start.
- In fill mode, RD_A/RD_D are skipped: the flow is WR_A -> WR_D -> WR_A ... and HWDATA=latched fill_value.
- Fill-mode latency is 2 cycles per word with zero wait states.
- src_addr is ignored in fill mode.
- When the macro is undefined, these ports do not exist and every transfer is a copy.

Test Plan:
- Zero-wait copy: preload 0x100..0x108 with 0x11111111, 0x22222222, 0x33333333 in a BRAM slave (HREADYOUT=1); start with src=0x100, dst=0x200, len=3.
  - Required: bus sequence R100, W200, R104, W204, R108, W208.
  - Required: dst words equal the source words; done high in cycle 13; busy high in cycles 1-13.
- Wait states: slave inserts 2 HREADY=0 cycles in each phase; len=1.
  - Required: HADDR/HTRANS/HWRITE/HWDATA stable throughout the waits; done in cycle 13.
- Zero length: start with len=0.
  - Required: HTRANS stays 2'b00; done=1 in cycle 1 only.
- Unaligned addresses and wrap: src=0x103, dst=0xFFFFFFFE, len=2.
  - Required: reads at 0x100 and 0x104; writes at 0xFFFFFFFC then 0x00000000.
- Start while busy and reset mid-transfer:
  - Pulse start during a len=4 copy: it is ignored, and exactly 8 transfers occur.
  - Assert HRESETn=0 during WR_A of word 2: HTRANS=00, busy=0 and done=0 immediately; after release the block sits in IDLE.
- AHB_DMA_FILL_EN defined: fill_mode=1, fill_value=0xDEADBEEF, dst=0x300, len=4.
  - Required: 4 writes only, no reads; 0x300-0x30C all read 0xDEADBEEF; done in cycle 9.
